// File: rtl/vga_fb_ctrl_pkg.sv
// Shared definitions for the framebuffer controller: visible-area sizes used by
// the sync generator, palette channel width and the pipeline record types.
package vga_fb_ctrl_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int PALETTE_W = 3;

  typedef struct packed {
    logic [PALETTE_W-1:0] red;
    logic [PALETTE_W-1:0] grn;
    logic [PALETTE_W-1:0] blu;
  } rgb_t;

  // One stage of the sync/blanking delay line.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_palette.sv
// Fixed 16-entry colour lookup: bit2/1/0 select red/green/blue, bit3 picks the
// bright level; index 8 is dark grey instead of black.
module vga_palette
  import vga_fb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] index,
  output rgb_t                  rgb
);

  logic [PALETTE_W-1:0] level;

  always_comb begin
    rgb   = '0;
    level = index[3] ? PALETTE_W'(7) : PALETTE_W'(4);
    if (index == DATA_WIDTH'(8)) begin
      rgb.red = PALETTE_W'(2);
      rgb.grn = PALETTE_W'(2);
      rgb.blu = PALETTE_W'(2);
    end else begin
      rgb.red = index[2] ? level : '0;
      rgb.grn = index[1] ? level : '0;
      rgb.blu = index[0] ? level : '0;
    end
  end

endmodule

// File: rtl/vga_fb_ctrl.sv
// Framebuffer controller: owns the tile RAM port, reads cells during active video,
// commits buffered loader writes during blanking and emits palette RGB with syncs.
module vga_fb_ctrl
  import vga_fb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4,
  parameter int CELL_SHIFT = 5,
  parameter int COLS       = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [9:0]            i_col,
  input  logic [9:0]            i_row,
  input  logic                  i_active,
  input  logic                  i_hsync,
  input  logic                  i_vsync,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_write_en,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic [PALETTE_W-1:0]  o_red,
  output logic [PALETTE_W-1:0]  o_grn,
  output logic [PALETTE_W-1:0]  o_blu,
  output logic                  o_hsync,
  output logic                  o_vsync
);

  // Loader handshake: a beat transfers on a clock edge where i_wr_valid and
  // o_wr_ready are both high; o_wr_ready depends only on registered state and
  // i_active, never on i_wr_valid, so the buffer can drain and refill in one cycle.
  logic                  r_pending;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  accept;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cell_addr;

  sync_t sync_in, sync_d0, sync_d1;
  rgb_t  pal_rgb, rgb_q;

  assign o_wr_ready = !r_pending || !i_active;
  assign accept     = i_wr_valid && o_wr_ready;
  assign commit     = r_pending && !i_active;

  // Modular arithmetic keeps the truncated result exact at ADDR_WIDTH.
  assign cell_addr = ADDR_WIDTH'(i_row >> CELL_SHIFT) * ADDR_WIDTH'(COLS)
                   + ADDR_WIDTH'(i_col >> CELL_SHIFT);

  always_comb begin
    o_ram_write_en = 1'b0;
    o_ram_addr     = cell_addr;
    o_ram_data     = r_wr_data;
    if (commit) begin
      o_ram_write_en = 1'b1;
      o_ram_addr     = r_wr_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (accept) begin
      r_pending <= 1'b1;
      r_wr_addr <= i_wr_addr;
      r_wr_data <= i_wr_data;
    end else if (commit) begin
      r_pending <= 1'b0;
    end
  end

  vga_palette #(.DATA_WIDTH(DATA_WIDTH)) u_palette (
    .index (i_ram_data),
    .rgb   (pal_rgb)
  );

  assign sync_in = '{active: i_active, hsync: i_hsync, vsync: i_vsync};

  // sync_d0 lines up with the RAM data returning; sync_d1 with the RGB register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_d0 <= SYNC_IDLE;
      sync_d1 <= SYNC_IDLE;
      rgb_q   <= '0;
    end else begin
      sync_d0 <= sync_in;
      sync_d1 <= sync_d0;
      rgb_q   <= sync_d0.active ? pal_rgb : '0;
    end
  end

  assign o_red   = rgb_q.red;
  assign o_grn   = rgb_q.grn;
  assign o_blu   = rgb_q.blu;
  assign o_hsync = sync_d1.hsync;
  assign o_vsync = sync_d1.vsync;

endmodule
